// File: rtl/render_pkg.sv
// Shared render-domain types and fixed-point helpers.
package render_pkg;

  localparam int unsigned FRAC_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} gen_state_t;

  function automatic logic signed [63:0] to_fixed(input int v, input int unsigned frac);
    return longint'(v) <<< frac;
  endfunction

  // Counter width that stays legal for a dimension of 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major raster position counter; x wraps into y, last pixel wraps to (0,0).
module raster_counter import render_pkg::*; #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 180
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [cnt_w(WIDTH)-1:0]   x,
  output logic [cnt_w(HEIGHT)-1:0]  y,
  output logic                      last_col,
  output logic                      last_pix
);

  localparam int unsigned XW = cnt_w(WIDTH);
  localparam int unsigned YW = cnt_w(HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (last_col) begin
        r_x <= '0;
        r_y <= last_pix ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign last_col = (r_x == XMAX);
  assign last_pix = last_col && (r_y == YMAX);

endmodule

// File: rtl/ray_generator.sv
// Walks a WIDTH x HEIGHT raster and streams one incrementally built camera ray per pixel.
module ray_generator import render_pkg::*; #(
  parameter int unsigned            SIZE   = 64,
  parameter int unsigned            FRAC   = FRAC_DEFAULT,
  parameter int unsigned            WIDTH  = 320,
  parameter int unsigned            HEIGHT = 180,
  parameter logic signed [SIZE-1:0] STEP   = SIZE'(to_fixed(1, FRAC - 8)),
  parameter logic signed [SIZE-1:0] FOCAL  = SIZE'(to_fixed(1, FRAC))
) (
  input  logic                          clk_render,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          frame_done,
  input  logic                          ray_axis_tready,
  output logic                          ray_axis_tvalid,
  output logic [2:0][SIZE-1:0]          ray_axis_tdata,
  output logic [cnt_w(WIDTH)-1:0]       pixel_x,
  output logic [cnt_w(HEIGHT)-1:0]      pixel_y
);

  localparam logic signed [SIZE-1:0] X0 = SIZE'(-(longint'(WIDTH / 2) * longint'(STEP)));
  localparam logic signed [SIZE-1:0] Y0 = SIZE'(longint'(HEIGHT / 2) * longint'(STEP));

  gen_state_t r_state, w_state_d;
  logic signed [SIZE-1:0] r_dir_x, r_dir_y, r_dir_z;
  logic w_clear, w_hs, w_last_col, w_last_pix;

  always_ff @(posedge clk_render or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_hs      = 1'b0;
    unique case (r_state)
      IDLE:   if (start) w_state_d = LOAD;
      LOAD: begin
        w_clear   = 1'b1;
        w_state_d = STREAM;
      end
      STREAM: begin
        w_hs = ray_axis_tready;
        if (ray_axis_tready && w_last_pix) w_state_d = DONE;
      end
      DONE:   w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Directions only ever step by STEP or reload, so no multipliers are needed.
  always_ff @(posedge clk_render or posedge rst) begin
    if (rst) begin
      r_dir_x <= '0;
      r_dir_y <= '0;
      r_dir_z <= '0;
    end else if (r_state == LOAD) begin
      r_dir_x <= X0;
      r_dir_y <= Y0;
      r_dir_z <= FOCAL;
    end else if (w_hs) begin
      if (!w_last_col) begin
        r_dir_x <= r_dir_x + STEP;
      end else if (!w_last_pix) begin
        r_dir_x <= X0;
        r_dir_y <= r_dir_y - STEP;
      end
    end
  end

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk      (clk_render),
    .rst      (rst),
    .clear    (w_clear),
    .advance  (w_hs),
    .x        (pixel_x),
    .y        (pixel_y),
    .last_col (w_last_col),
    .last_pix (w_last_pix)
  );

  assign ray_axis_tvalid = (r_state == STREAM);
  assign busy            = (r_state != IDLE);
  assign frame_done      = (r_state == DONE);
  assign ray_axis_tdata  = {r_dir_z, r_dir_y, r_dir_x};

endmodule
